// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings and FSM state type for the iterative multiply/divide unit
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-divide step (trial subtract, next remainder, quotient bit)
module mdu_div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem,
    input  logic         in_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] trial;

    assign shifted  = {rem, in_bit};
    assign trial    = shifted - {1'b0, divisor};
    // No borrow out of the N+1-bit subtract means the divisor fits.
    assign q_bit    = ~trial[N];
    assign rem_next = q_bit ? trial[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers; divider enabled by MDU_DIV_EN
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N) + 1;

    mdu_state_t     state;
    logic [1:0]     op_q;
    logic [N-1:0]   b_mag;
    logic           sa;
    logic           sb;
    logic [CW-1:0]  cnt;
    // Multiply: {partial product, multiplier bits}. Divide: {remainder, dividend/quotient bits}.
    logic [2*N-1:0] acc;

    logic           in_signed;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   a_abs;
    logic [N-1:0]   b_abs;
    logic           short_path;

    assign in_signed = ~op[0];
    assign a_neg     = in_signed & A[N-1];
    assign b_neg     = in_signed & B[N-1];
    assign a_abs     = a_neg ? -A : A;
    assign b_abs     = b_neg ? -B : B;

    logic [N:0]     add_sum;
    logic [2*N-1:0] mul_next;
    logic [2*N-1:0] iter_next;
    logic           res_neg;
    logic [2*N-1:0] prod_fix;

    assign add_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, b_mag} : {(N+1){1'b0}});
    assign mul_next = {add_sum, acc[N-1:1]};
    assign res_neg  = ~op_q[0] & (sa ^ sb);
    assign prod_fix = res_neg ? -acc : acc;

`ifdef MDU_DIV_EN
    logic           dz;
    logic [N-1:0]   div_rem;
    logic           div_q;
    logic [N-1:0]   quo_fix;
    logic [N-1:0]   rem_fix;
    logic [N-1:0]   a_orig;

    mdu_div_step #(.N(N)) u_div_step (
        .rem      (acc[2*N-1:N]),
        .in_bit   (acc[N-1]),
        .divisor  (b_mag),
        .rem_next (div_rem),
        .q_bit    (div_q)
    );

    assign iter_next  = op_q[1] ? {div_rem, acc[N-2:0], div_q} : mul_next;
    assign quo_fix    = res_neg ? -acc[N-1:0] : acc[N-1:0];
    assign rem_fix    = sa ? -acc[2*N-1:N] : acc[2*N-1:N];
    // The low half still holds |A| on the divide-by-zero path; re-apply its sign.
    assign a_orig     = sa ? -acc[N-1:0] : acc[N-1:0];
    assign short_path = op[1] & (B == '0);
`else
    assign iter_next  = mul_next;
    assign short_path = op[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            op_q        <= MDU_MULT;
            b_mag       <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
`ifdef MDU_DIV_EN
            dz          <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        b_mag <= b_abs;
                        sa    <= a_neg;
                        sb    <= b_neg;
                        acc   <= {{N{1'b0}}, a_abs};
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef MDU_DIV_EN
                        dz    <= short_path;
`endif
                        state <= short_path ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc <= iter_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
`ifdef MDU_DIV_EN
                    div_by_zero <= dz;
                    if (op_q[1]) begin
                        hi <= dz ? a_orig : rem_fix;
                        lo <= dz ? {N{1'b1}} : quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
`else
                    div_by_zero <= 1'b0;
                    if (op_q[1]) begin
                        hi <= '0;
                        lo <= '0;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
